assoc_cache_tag_unit: RTL and testbench

//  Parametrised set-associative cache tag/hit unit with true-LRU replacement,

---
 rtl/assoc_cache_tag_unit_if.sv | 26 ++
 rtl/assoc_cache_tag_unit.sv | 184 ++++++++++++++++++
 tb/tb_assoc_cache_tag_unit.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/assoc_cache_tag_unit_if.sv
// Request/response handshake bundle for the set-associative tag unit.
// The slave modport is the cache side; master is the address source / consumer.
interface assoc_cache_tag_unit_if #(
  parameter int ADDR_W = 24,
  parameter int AGE_W  = 4
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              flush;
  logic              resp_valid;
  logic              resp_ready;
  logic              resp_hit;
  logic [AGE_W-1:0]  resp_way;
  logic              busy;

  modport slave (
    input  req_valid, req_addr, flush, resp_ready,
    output req_ready, resp_valid, resp_hit, resp_way, busy
  );

  modport master (
    output req_valid, req_addr, flush, resp_ready,
    input  req_ready, resp_valid, resp_hit, resp_way, busy
  );
endinterface

// File: rtl/assoc_cache_tag_unit.sv
// Set-associative tag/hit unit with true-LRU ages, allocate-on-miss and a one-set-per-cycle flush.
// Optional CACHE_STATS_EN adds saturating access/hit counters (stat_access, stat_hit).

// One way of the selected set: tag match plus its LRU age update.
module assoc_cache_way_cmp #(
  parameter int TAG_W = 14,
  parameter int AGE_W = 4
) (
  input  logic             vld_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic [TAG_W-1:0] req_tag_i,
  input  logic [AGE_W-1:0] age_i,
  input  logic [AGE_W-1:0] vic_age_i,
  input  logic             is_vic_i,
  output logic             hit_o,
  output logic             oldest_o,
  output logic [AGE_W-1:0] age_nxt_o
);
  assign hit_o    = vld_i && (tag_i == req_tag_i);
  // WAYS is a power of two, so age WAYS-1 is all ones.
  assign oldest_o = &age_i;
  assign age_nxt_o = is_vic_i              ? '0 :
                     (age_i < vic_age_i)   ? age_i + AGE_W'(1) : age_i;
endmodule

module assoc_cache_tag_unit #(
  parameter int ADDR_W      = 24,
  parameter int OFFSET_BITS = 6,
  parameter int SET_BITS    = 4,
  parameter int WAYS        = 16
) (
  input  logic clk,
  input  logic rst_n,
  assoc_cache_tag_unit_if.slave bus
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0] stat_access,
  output logic [31:0] stat_hit
`endif
);
  localparam int SETS  = 1 << SET_BITS;
  localparam int AGE_W = $clog2(WAYS);
  localparam int TAG_W = ADDR_W - SET_BITS - OFFSET_BITS;

  typedef enum logic {IDLE, FLUSH} state_e;

  state_e                                  state_q, state_d;
  logic [SET_BITS-1:0]                     ptr_q, ptr_d;
  logic [SETS-1:0][WAYS-1:0][TAG_W-1:0]    tag_q;
  logic [SETS-1:0][WAYS-1:0]               valid_q;
  logic [SETS-1:0][WAYS-1:0][AGE_W-1:0]    age_q;
  logic                                    resp_valid_q, resp_hit_q;
  logic [AGE_W-1:0]                        resp_way_q;

  logic [SET_BITS-1:0]                     set_idx;
  logic [TAG_W-1:0]                        req_tag;
  logic [WAYS-1:0][TAG_W-1:0]              row_tag;
  logic [WAYS-1:0]                         row_vld;
  logic [WAYS-1:0][AGE_W-1:0]              row_age;
  logic [WAYS-1:0]                         hit_vec, old_vec;
  logic [WAYS-1:0][AGE_W-1:0]              age_nxt;
  logic [AGE_W-1:0]                        vic, vic_age;
  logic                                    hit_any, accept;
  logic                                    offset_unused;

  assign set_idx       = bus.req_addr[OFFSET_BITS +: SET_BITS];
  assign req_tag       = bus.req_addr[ADDR_W-1 -: TAG_W];
  assign offset_unused = ^bus.req_addr[OFFSET_BITS-1:0];
  assign row_tag       = tag_q[set_idx];
  assign row_vld       = valid_q[set_idx];
  assign row_age       = age_q[set_idx];

  // Ready also drops on a flush cycle so the master never sees a handshake that is not taken.
  assign bus.req_ready  = (state_q == IDLE) && !bus.flush && (!resp_valid_q || bus.resp_ready);
  assign accept         = bus.req_valid && bus.req_ready;
  assign bus.busy       = (state_q == FLUSH);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_hit   = resp_hit_q;
  assign bus.resp_way   = resp_way_q;

  genvar w;
  generate
    for (w = 0; w < WAYS; w++) begin : g_way
      assoc_cache_way_cmp #(.TAG_W(TAG_W), .AGE_W(AGE_W)) u_cmp (
        .vld_i     (row_vld[w]),
        .tag_i     (row_tag[w]),
        .req_tag_i (req_tag),
        .age_i     (row_age[w]),
        .vic_age_i (vic_age),
        .is_vic_i  (vic == AGE_W'(w)),
        .hit_o     (hit_vec[w]),
        .oldest_o  (old_vec[w]),
        .age_nxt_o (age_nxt[w])
      );
    end
  endgenerate

  assign hit_any = |hit_vec;
  assign vic_age = row_age[vic];

  // Descending scans so the lowest matching index wins.
  always_comb begin
    vic = '0;
    if (hit_any) begin
      for (int i = WAYS-1; i >= 0; i--) if (hit_vec[i]) vic = AGE_W'(i);
    end else if (!(&row_vld)) begin
      for (int i = WAYS-1; i >= 0; i--) if (!row_vld[i]) vic = AGE_W'(i);
    end else begin
      for (int i = WAYS-1; i >= 0; i--) if (old_vec[i]) vic = AGE_W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: if (bus.flush) begin
        state_d = FLUSH;
        ptr_d   = '0;
      end
      FLUSH: begin
        ptr_d = ptr_q + SET_BITS'(1);
        if (ptr_q == SET_BITS'(SETS-1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++)
        for (int i = 0; i < WAYS; i++) begin
          tag_q[s][i]   <= '0;
          valid_q[s][i] <= 1'b0;
          age_q[s][i]   <= AGE_W'(i);
        end
    end else if (accept) begin
      age_q[set_idx] <= age_nxt;
      if (!hit_any) begin
        tag_q[set_idx][vic]   <= req_tag;
        valid_q[set_idx][vic] <= 1'b1;
      end
    end else if (state_q == FLUSH) begin
      valid_q[ptr_q] <= '0;
      for (int i = 0; i < WAYS; i++) age_q[ptr_q][i] <= AGE_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_way_q   <= '0;
    end else if (accept) begin
      resp_valid_q <= 1'b1;
      resp_hit_q   <= hit_any;
      resp_way_q   <= vic;
    end else if (bus.resp_ready) begin
      resp_valid_q <= 1'b0;
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_access <= '0;
      stat_hit    <= '0;
    end else if (accept) begin
      if (stat_access != 32'hFFFF_FFFF) stat_access <= stat_access + 32'd1;
      if (hit_any && stat_hit != 32'hFFFF_FFFF) stat_hit <= stat_hit + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_assoc_cache_tag_unit.sv
// Directed bench for assoc_cache_tag_unit: allocation, LRU, back-pressure, flush, reset.
module tb_assoc_cache_tag_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  assoc_cache_tag_unit_if #(.ADDR_W(24), .AGE_W(4)) bus ();

`ifdef CACHE_STATS_EN
  logic [31:0] stat_access, stat_hit;
`endif

  assoc_cache_tag_unit #(.ADDR_W(24), .OFFSET_BITS(6), .SET_BITS(4), .WAYS(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef CACHE_STATS_EN
    ,
    .stat_access (stat_access),
    .stat_hit    (stat_hit)
`endif
  );

  task automatic do_reset();
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.flush = 1'b0; bus.resp_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Issue one request from a negedge; returns the response seen just after the accept edge.
  task automatic req(input logic [23:0] a, output logic h, output logic [3:0] w, output logic v);
    int n = 0;
    bus.req_addr = a; bus.req_valid = 1'b1; bus.resp_ready = 1'b1;
    while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    v = (n < 50) ? bus.resp_valid : 1'b0;
    h = bus.resp_hit; w = bus.resp_way;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.flush = 1'b0; bus.resp_ready = 1'b0; bus.req_addr = '0;
    #1;
    checks++;
    if (bus.resp_valid !== 1'b0 || bus.resp_hit !== 1'b0 || bus.resp_way !== 4'd0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_state vld=%b hit=%b way=%0d busy=%b expected 0 0 0 0",
               bus.resp_valid, bus.resp_hit, bus.resp_way, bus.busy);
    end
    do_reset();
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready got=%b expected 1", bus.req_ready);
    end
  endtask

  task automatic test_miss_hit();
    logic h, v; logic [3:0] w;
    req(24'h000040, h, w, v);
    checks++;
    if (v !== 1'b1 || h !== 1'b0 || w !== 4'd0) begin
      failures++; $display("FAIL first_miss vld=%b hit=%b way=%0d expected 1 0 0", v, h, w);
    end
    req(24'h000040, h, w, v);
    checks++;
    if (v !== 1'b1 || h !== 1'b1 || w !== 4'd0) begin
      failures++; $display("FAIL repeat_hit vld=%b hit=%b way=%0d expected 1 1 0", v, h, w);
    end
  endtask

  task automatic test_offset();
    logic h, v; logic [3:0] w;
    do_reset();
    req(24'h000040, h, w, v);
    checks++;
    if (h !== 1'b0 || w !== 4'd0) begin
      failures++; $display("FAIL offset_miss hit=%b way=%0d expected 0 0", h, w);
    end
    req(24'h00007F, h, w, v);
    checks++;
    if (h !== 1'b1 || w !== 4'd0) begin
      failures++; $display("FAIL offset_hit hit=%b way=%0d expected 1 0", h, w);
    end
  endtask

  task automatic fill_set1(input string tag);
    logic h, v; logic [3:0] w;
    for (int n = 0; n < 16; n++) begin
      req(24'h000040 + 24'(n) * 24'h400, h, w, v);
      checks++;
      if (v !== 1'b1 || h !== 1'b0 || w !== 4'(n)) begin
        failures++; $display("FAIL %s_fill n=%0d hit=%b way=%0d expected 0 %0d", tag, n, h, w, n);
      end
    end
  endtask

  task automatic test_evict();
    logic h, v; logic [3:0] w;
    do_reset();
    fill_set1("evict");
    req(24'h000040 + 24'd16 * 24'h400, h, w, v);
    checks++;
    if (h !== 1'b0 || w !== 4'd0) begin
      failures++; $display("FAIL evict_n16 hit=%b way=%0d expected 0 0", h, w);
    end
    // Way 1 is now oldest: n=16 took way 0 to MRU and aged the rest.
    req(24'h000040, h, w, v);
    checks++;
    if (h !== 1'b0 || w !== 4'd1) begin
      failures++; $display("FAIL evict_rereq_n0 hit=%b way=%0d expected 0 1", h, w);
    end
  endtask

  task automatic test_lru_on_hit();
    logic h, v; logic [3:0] w;
    do_reset();
    fill_set1("lru");
    req(24'h000040, h, w, v);
    checks++;
    if (h !== 1'b1 || w !== 4'd0) begin
      failures++; $display("FAIL lru_hit_n0 hit=%b way=%0d expected 1 0", h, w);
    end
    req(24'h000040 + 24'd16 * 24'h400, h, w, v);
    checks++;
    if (h !== 1'b0 || w !== 4'd1) begin
      failures++; $display("FAIL lru_victim hit=%b way=%0d expected 0 1", h, w);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.resp_ready = 1'b0; bus.req_valid = 1'b1; bus.req_addr = 24'h000040;
    @(negedge clk);
    bus.req_addr = 24'h000440;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b1 || bus.resp_hit !== 1'b0 || bus.resp_way !== 4'd0) begin
        failures++;
        $display("FAIL stall_hold cyc=%0d rdy=%b vld=%b hit=%b way=%0d expected 0 1 0 0",
                 i, bus.req_ready, bus.resp_valid, bus.resp_hit, bus.resp_way);
      end
      @(negedge clk);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_hit !== 1'b0 || bus.resp_way !== 4'd1) begin
      failures++; $display("FAIL b2b_first vld=%b hit=%b way=%0d expected 1 0 1", bus.resp_valid, bus.resp_hit, bus.resp_way);
    end
    bus.req_addr = 24'h000040;
    @(negedge clk);
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_hit !== 1'b1 || bus.resp_way !== 4'd0) begin
      failures++; $display("FAIL b2b_second vld=%b hit=%b way=%0d expected 1 1 0", bus.resp_valid, bus.resp_hit, bus.resp_way);
    end
    bus.req_addr = 24'h000840;
    @(negedge clk);
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_hit !== 1'b0 || bus.resp_way !== 4'd2) begin
      failures++; $display("FAIL b2b_third vld=%b hit=%b way=%0d expected 1 0 2", bus.resp_valid, bus.resp_hit, bus.resp_way);
    end
    bus.req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.resp_valid !== 1'b0) begin
      failures++; $display("FAIL b2b_drain vld=%b expected 0", bus.resp_valid);
    end
  endtask

  task automatic test_flush();
    logic h, v; logic [3:0] w;
    int cnt = 0;
    do_reset();
    req(24'h000040, h, w, v);
    req(24'h000040, h, w, v);
    checks++;
    if (h !== 1'b1) begin
      failures++; $display("FAIL flush_prehit hit=%b expected 1", h);
    end
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    checks++;
    if (bus.req_ready !== 1'b0) begin
      failures++; $display("FAIL flush_ready rdy=%b expected 0", bus.req_ready);
    end
    while (bus.busy && cnt < 100) begin cnt++; @(negedge clk); end
    checks++;
    if (cnt != 16) begin
      failures++; $display("FAIL flush_busy_cycles got=%0d expected 16", cnt);
    end
    req(24'h000040, h, w, v);
    checks++;
    if (v !== 1'b1 || h !== 1'b0 || w !== 4'd0) begin
      failures++; $display("FAIL flush_postmiss vld=%b hit=%b way=%0d expected 1 0 0", v, h, w);
    end
`ifdef CACHE_STATS_EN
    checks++;
    if (stat_access !== 32'd3 || stat_hit !== 32'd1) begin
      failures++; $display("FAIL stats access=%0d hit=%0d expected 3 1", stat_access, stat_hit);
    end
`endif
  endtask

  task automatic test_reset_mid_flush();
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.resp_valid !== 1'b0) begin
      failures++; $display("FAIL reset_mid_flush busy=%b vld=%b expected 0 0", bus.busy, bus.resp_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_miss_hit();
    test_offset();
    test_evict();
    test_lru_on_hit();
    test_back_to_back();
    test_flush();
    test_reset_mid_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
